// File: rtl/memory_stage.sv
// Memory-access stage: scalar and 8-beat vector load/store over a 32-bit synchronous data-memory port.
// Latency: scalar/non-memory result 1 cycle, vector store 8 cycles, vector load 9 cycles (out_valid is a one-cycle pulse).
// Backpressure: Stall holds execute while a vector transfer is in flight; address range check built with MEM_ADDR_CHECK_EN.
module memory_stage #(
  parameter int DATA_W    = 32,
  parameter int VEC_W     = 256,
  parameter int ADDR_W    = 32,
  parameter int ADDR_STEP = 1,
  parameter int MEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              VecMem,
  input  logic [ADDR_W-1:0] ALUresult,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [VEC_W-1:0]  VALUresult,
  output logic              Stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [ADDR_W-1:0] ALUout,
  output logic [DATA_W-1:0] ReadData,
  output logic [VEC_W-1:0]  ReadDataV,
  output logic              mem_fault
);

  localparam int BEATS = VEC_W / DATA_W;
  localparam int BW    = $clog2(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] VSTORE     = 2'd1;
  localparam logic [1:0] VLOAD      = 2'd2;
  localparam logic [1:0] VLOAD_LAST = 2'd3;

  logic [1:0]        state;
  logic [BW-1:0]     beat;
  logic [BW-1:0]     lane_idx;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] beat_addr;
  logic [VEC_W-1:0]  vbuf;       // store data during VSTORE, partial load lanes during VLOAD
  logic [ADDR_W:0]   vec_end;
  logic              chk_en;
  logic              acc, is_mem, is_st, range_bad, fault, go_vec;
  logic              we_c, re_c, stall_c;

`ifdef MEM_ADDR_CHECK_EN
  assign chk_en = 1'b1;
`else
  assign chk_en = 1'b0;
`endif

  assign acc       = (state == IDLE) & in_valid;
  assign is_mem    = MemRead | MemWrite;
  assign is_st     = MemWrite;            // read+write together is a store
  assign vec_end   = {1'b0, ALUresult} + (ADDR_W+1)'((BEATS - 1) * ADDR_STEP);
  assign range_bad = VecMem ? (vec_end[ADDR_W] | (vec_end[ADDR_W-1:0] >= ADDR_W'(MEM_DEPTH)))
                            : (ALUresult >= ADDR_W'(MEM_DEPTH));
  assign fault     = chk_en & is_mem & range_bad;
  assign go_vec    = acc & VecMem & is_mem & ~fault;
  assign beat_addr = base + ADDR_W'(beat) * ADDR_W'(ADDR_STEP);
  assign lane_idx  = beat - BW'(1);
  assign ReadData  = mem_rdata;

  // Memory strobes, address/data mux and upstream stall for the current cycle
  always_comb begin
    we_c      = 1'b0;
    re_c      = 1'b0;
    stall_c   = 1'b0;
    mem_addr  = ALUresult;
    mem_wdata = WriteData;
    case (state)
      IDLE: begin
        if (acc & is_mem & ~fault) begin
          we_c      = is_st;
          re_c      = ~is_st;
          mem_wdata = VecMem ? VALUresult[DATA_W-1:0] : WriteData;
          stall_c   = VecMem;
        end
      end
      VSTORE: begin
        we_c      = 1'b1;
        mem_addr  = beat_addr;
        mem_wdata = vbuf[beat*DATA_W +: DATA_W];
        stall_c   = (beat != LAST_BEAT);
      end
      VLOAD: begin
        re_c     = 1'b1;
        mem_addr = beat_addr;
        stall_c  = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset kills strobes and stall immediately, not only at the next edge
  assign mem_we = we_c & rst;
  assign mem_re = re_c & rst;
  assign Stall  = stall_c & rst;

  // Sequencer: accept, vector beat counting, load assembly and result pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      beat      <= '0;
      base      <= '0;
      vbuf      <= '0;
      out_valid <= 1'b0;
      ALUout    <= '0;
      ReadDataV <= '0;
      mem_fault <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (acc) begin
            ALUout <= ALUresult;
            if (go_vec) begin
              base <= ALUresult;
              beat <= BW'(1);        // beat 0 goes out this cycle from live inputs
              if (is_st) begin
                vbuf  <= VALUresult;
                state <= VSTORE;
              end else begin
                state <= VLOAD;
              end
            end else begin
              out_valid <= 1'b1;
              mem_fault <= fault;
            end
          end
        end
        VSTORE: begin
          beat <= beat + BW'(1);
          if (beat == LAST_BEAT) begin
            state     <= IDLE;
            out_valid <= 1'b1;
            mem_fault <= 1'b0;
          end
        end
        VLOAD: begin
          // read data lags the strobe by one cycle, so this is the previous beat's lane
          vbuf[lane_idx*DATA_W +: DATA_W] <= mem_rdata;
          beat <= beat + BW'(1);
          if (beat == LAST_BEAT) state <= VLOAD_LAST;
        end
        default: begin
          ReadDataV <= {mem_rdata, vbuf[VEC_W-DATA_W-1:0]};
          out_valid <= 1'b1;
          mem_fault <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
